// File: rtl/rand_param_bank_pkg.sv
// Shared constants, state encoding and the zero-seed guard for rand_param_bank.
package rand_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_ONE  = 16'h0001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GEN     = 2'd1,
        PENDING = 2'd2,
        COMMIT  = 2'd3
    } state_e;

    // An all-zero Galois LFSR would lock up, so zero is mapped to one.
    function automatic logic [15:0] nonzero_seed(input logic [15:0] v);
        return (v == 16'h0000) ? LFSR_ONE : v;
    endfunction

endpackage

// File: rtl/rand_param_bank_lfsr16.sv
// 16-bit right-shifting Galois LFSR with zero-safe reset and load.
module lfsr16
    import rand_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q,
    output logic [15:0] next
);

    localparam logic [15:0] SEED_SAFE = nonzero_seed(SEED);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next-step value and register input selection
    always_comb begin
        next = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
        q_d  = q_q;
        if (load) begin
            q_d = nonzero_seed(load_val);
        end else if (en) begin
            q_d = next;
        end else begin
            q_d = q_q;
        end
    end

    // LFSR state register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            q_q <= SEED_SAFE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rand_param_bank.sv
// Generates a pseudo-random parameter word set into shadow registers on each
// step request and commits it to rnd_bus atomically at the next frame start.
module rand_param_bank
    import rand_pkg::*;
#(
    parameter int          N_WORDS = 10,
    parameter int          WORD_W  = 13,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                       clk_in,
    input  logic                       reset,
    input  logic                       step_pulse,
    input  logic                       frame_start,
    input  logic                       seed_load,
    input  logic [15:0]                seed_val,
    output logic [N_WORDS*WORD_W-1:0]  rnd_bus,
    output logic                       updated,
    output logic                       busy
);

    localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);

    state_e                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [WORD_W-1:0]           shadow_q [N_WORDS];
    logic [WORD_W-1:0]           shadow_d [N_WORDS];
    logic [N_WORDS*WORD_W-1:0]   rnd_bus_q, rnd_bus_d;
    logic                        updated_q, updated_d;
    logic                        busy_q, busy_d;
    logic                        lfsr_en_s;
    logic                        lfsr_load_s;
    logic [15:0]                 lfsr_q_s;
    logic [15:0]                 lfsr_next_s;
    logic                        lfsr_unused_s;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (lfsr_en_s),
        .load     (lfsr_load_s),
        .load_val (seed_val),
        .q        (lfsr_q_s),
        .next     (lfsr_next_s)
    );

    assign lfsr_unused_s = ^{lfsr_q_s, lfsr_next_s[15:WORD_W]};

    // Next-state, shadow fill and commit logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        rnd_bus_d   = rnd_bus_q;
        updated_d   = 1'b0;
        lfsr_en_s   = 1'b0;
        lfsr_load_s = 1'b0;
        case (state_q)
            IDLE: begin
                // Seeds only land here so one word set never mixes two seeds.
                lfsr_load_s = seed_load;
                if (step_pulse) begin
                    state_d = GEN;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            GEN: begin
                lfsr_en_s       = 1'b1;
                shadow_d[idx_q] = lfsr_next_s[WORD_W-1:0];
                idx_d           = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (idx_q == IDX_LAST) begin
                    state_d = PENDING;
                end else begin
                    state_d = GEN;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    state_d = COMMIT;
                end else begin
                    state_d = PENDING;
                end
            end
            COMMIT: begin
                for (int k = 0; k < N_WORDS; k++) begin
                    rnd_bus_d[k*WORD_W +: WORD_W] = shadow_q[k];
                end
                updated_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == GEN) || (state_d == PENDING);
    end

    // State, shadow and output registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= {IDX_W{1'b0}};
            rnd_bus_q <= {(N_WORDS*WORD_W){1'b0}};
            updated_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int k = 0; k < N_WORDS; k++) begin
                shadow_q[k] <= {WORD_W{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rnd_bus_q <= rnd_bus_d;
            updated_q <= updated_d;
            busy_q    <= busy_d;
            for (int k = 0; k < N_WORDS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign rnd_bus = rnd_bus_q;
    assign updated = updated_q;
    assign busy    = busy_q;

endmodule
